// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   NOP_INSTR_C      : bubble encoding inserted into IF/ID (addi x0,x0,0)
//   RESET_PC_DEFAULT : first fetch address after reset
//   fetch_state_t    : fetch controller states (idle / request / wait)
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR_C      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush/stall priority and bubble insertion.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : replace contents with a bubble (pc held)
//   stall               : hold all contents
//   load                : a real instruction is available this cycle
//   load_instr, load_pc : the instruction and its PC
//   instr_d, pc_d, pc_plus4_d, valid_d : register outputs to decode
module if_id_reg #(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    load_instr,
    input  logic [ADDRESS_WIDTH-1:0] load_pc,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d
);

    // Bubbles (flush or nothing to load) keep pc_d/pc_plus4_d so decode
    // still sees the last real PC pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr_d    <= load_instr;
                pc_d       <= load_pc;
                pc_plus4_d <= load_pc + ADDRESS_WIDTH'(4);
                valid_d    <= 1'b1;
            end else begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding fetch controller,
// one-entry fetch buffer, wrong-path drop logic and the IF/ID register.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   stall_f, stall_d, flush_d    : hazard-unit controls
//   pc_src_e, pc_target_e        : redirect from execute
//   imem_req_valid/ready/addr    : fetch request channel
//   imem_rsp_valid/data          : in-order fetch responses
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID outputs to decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                        ADDRESS_WIDTH = 32,
    parameter int                        DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEFAULT),
    parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = DATA_WIDTH'(NOP_INSTR_C)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d
);

    fetch_state_t             state;
    logic [ADDRESS_WIDTH-1:0] pc_f;
    logic [ADDRESS_WIDTH-1:0] req_pc;
    logic                     drop;
    logic                     fb_v;
    logic [DATA_WIDTH-1:0]    fb_data;
    logic [ADDRESS_WIDTH-1:0] fb_pc;

    logic handshake;
    logic rsp_accept;
    logic rsp_bypass;
    logic rsp_to_fb;
    logic fb_consume;
    logic fb_free;
    logic launch;

    assign imem_req_valid = (state == ST_REQ);
    assign imem_req_addr  = pc_f;

    assign handshake  = (state == ST_REQ) & imem_req_ready;
    // A response that arrives with a redirect or while dropping is wrong-path.
    assign rsp_accept = (state == ST_WAIT) & imem_rsp_valid & ~drop & ~pc_src_e;
    assign rsp_bypass = rsp_accept & ~fb_v & ~stall_d & ~flush_d;
    assign rsp_to_fb  = rsp_accept & ~rsp_bypass;
    assign fb_consume = fb_v & ~stall_d & ~flush_d;
    // The buffer must be free after this cycle, otherwise the next response
    // would have nowhere to go.
    assign fb_free    = (~fb_v | fb_consume) & ~rsp_to_fb;
    // launch is only evaluated in IDLE and in WAIT on the completing
    // response, so no fetch remains outstanding at those points.
    assign launch     = ~stall_f & fb_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_v    <= 1'b0;
            fb_data <= NOP_INSTR;
            fb_pc   <= '0;
        end else if (pc_src_e) begin
            fb_v <= 1'b0;
        end else if (rsp_to_fb) begin
            fb_v    <= 1'b1;
            fb_data <= imem_rsp_data;
            fb_pc   <= req_pc;
        end else if (fb_consume) begin
            fb_v <= 1'b0;
        end
    end

    // A redirect overrides stall_f and every sequential PC update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc_f   <= RESET_PC;
            req_pc <= RESET_PC;
            drop   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_src_e) begin
                        pc_f  <= pc_target_e;
                        state <= ST_REQ;
                    end else if (launch) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (handshake) begin
                        req_pc <= pc_f;
                        state  <= ST_WAIT;
                    end
                    if (pc_src_e) begin
                        pc_f <= pc_target_e;
                        if (handshake) begin
                            drop <= 1'b1;
                        end
                    end else if (handshake) begin
                        pc_f <= pc_f + ADDRESS_WIDTH'(4);
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop <= 1'b0;
                        if (pc_src_e) begin
                            pc_f  <= pc_target_e;
                            state <= ST_REQ;
                        end else if (launch) begin
                            state <= ST_REQ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (pc_src_e) begin
                        pc_f <= pc_target_e;
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .NOP_INSTR     (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_d),
        .stall      (stall_d),
        .load       (fb_v | rsp_bypass),
        .load_instr (fb_v ? fb_data : imem_rsp_data),
        .load_pc    (fb_v ? fb_pc : req_pc),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with variable-latency responses.
- Obeys stall_f/stall_d/flush_d/pc_src_e from the hazard unit; delivers instr/pc/pc+4 to decode.
- At most one outstanding fetch; a one-entry fetch buffer absorbs responses while decode is stalled.

Parameters:
ADDRESS_WIDTH, 32, PC/memory address width
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
stall_f  in  1  hazard: hold PC, launch no new fetch
stall_d  in  1  hazard: hold IF/ID register
flush_d  in  1  hazard: bubble IF/ID register
pc_src_e  in  1  taken branch/jump resolved in E
pc_target_e  in  ADDRESS_WIDTH  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDRESS_WIDTH  fetch address (word aligned)
imem_rsp_valid  in  1  response data valid, one per accepted request, in order
imem_rsp_data  in  DATA_WIDTH  fetched instruction
instr_d  out  DATA_WIDTH  IF/ID instruction
pc_d  out  ADDRESS_WIDTH  IF/ID PC
pc_plus4_d  out  ADDRESS_WIDTH  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc_f=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, fb_v=0, drop=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0. Memory side must be reset together; responses from before reset are not expected.
- imem_req_valid = (state==REQ); imem_req_addr = pc_f. Address stays stable while valid & ~ready, except on redirect.
- States:
  - IDLE -> REQ when launch = ~stall_f & (fb empty or consumed this cycle) & ~outstanding. First REQ is one cycle after reset release.
  - REQ -> WAIT on imem_req_ready: req_pc<=pc_f, pc_f<=pc_f+4 (mod 2^ADDRESS_WIDTH).
  - WAIT, on imem_rsp_valid:
    - drop=1: discard data, clear drop.
    - drop=0 and bypass condition (fb empty, ~stall_d, ~flush_d): data goes directly to IF/ID.
    - otherwise: data goes to fb {data, req_pc}, fb_v=1.
    - Next state: REQ if launch holds, else IDLE.
- Peak throughput with 1-cycle memory and always-ready: one instruction per 2 cycles.
- IF/ID update each cycle, in priority order:
  1. flush_d: valid_d=0, instr_d=NOP_INSTR, pc_d held.
  2. stall_d: hold all.
  3. fb_v: load fb, valid_d=1, fb_v cleared.
  4. bypass response: load it, valid_d=1.
  5. otherwise: bubble (valid_d=0, instr_d=NOP_INSTR).
  - pc_plus4_d = pc_d+4, registered alongside pc_d, wraps.
- Redirect (pc_src_e=1) takes priority over stall_f and all PC updates:
  - pc_f<=pc_target_e; fb_v<=0.
  - In WAIT without a response that cycle: drop<=1.
  - In WAIT with a response that cycle: response discarded.
  - In REQ with a handshake that cycle: transaction counts, go to WAIT with drop=1, pc_f=target (not target+4).
  - In REQ without a handshake: stay in REQ, new address presented next cycle.
  - In IDLE: go to REQ next cycle regardless of stall_f.
- stall_f never retracts an asserted request; it only blocks IDLE->REQ.
- No misalignment check; pc_target_e[1:0] is passed to memory unchanged.

Decomposition:
- Shared pipeline package: NOP_INSTR constant, fetch state encoding (IDLE/REQ/WAIT), RESET_PC default.
- One sub-module, if_id_reg: data register with stall/flush priority and bubble insertion.
- FSM, PC, fetch buffer and drop logic stay in fetch_stage.

Test Plan:
- Reset release, ready=1, 1-cycle response returning addr|0xA000_0000 -> requests at 0x0, 0x4, 0x8 on alternate cycles; pc_d 0x0/0x4/0x8 with matching instr_d; pc_plus4_d = pc_d+4; valid_d=1.
- stall_d=1 for 3 cycles while a response arrives -> IF/ID frozen, response held in fb, no new request; after release, fb instruction appears next cycle and the following request issues.
- pc_src_e=1, pc_target_e=0x100 while in WAIT, response 2 cycles later -> that response never reaches instr_d; next request address 0x100; drop cleared.
- flush_d=1 with valid instruction in IF/ID -> next cycle valid_d=0, instr_d=0x00000013.
- imem_req_ready low 4 cycles, stall_f toggling -> imem_req_valid stays 1, addr stable at 0x8; one handshake when ready rises.
- rst_n low mid-WAIT -> outputs immediately at reset values; first post-reset request addr=RESET_PC.
